snd_playctrl: RTL and testbench

- Playback engine directly downstream of the sound register block.
- Consumes the latched command, start address, length, volume, loop and mute controls.
- Fetches 32-bit sample words from VRAM over a req/ack port, scales and mutes them, and emits one 16-bit signed PCM sample per sample-rate tick to the DAC interface.
- Returns busy/done/underrun/position status for software readback.

---
 rtl/snd_playctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_snd_playctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_playctrl.sv
// snd_playctrl -- sound playback engine.
//
// Fetches 32-bit sample words from VRAM over a single-outstanding req/ack
// port. Each word holds two signed 16-bit samples, with the low half played
// first. Samples are scaled by REG_VOLUME, muted if requested, and emitted to
// the DAC one per SMP_TICK. Status (busy/done/underrun/position) is returned
// for software readback.
//
// Ports:
//   CLK, RST_X          clock, asynchronous active-low reset
//   REG_CMD             0/3 stop, 1 play, 2 pause (level)
//   REG_VRAMADR/LEN     start word address / word count (latched at start/loop)
//   REG_VOLUME/MUTE     gain (128 = unity) / force output to zero
//   REG_LOOP            restart from REG_VRAMADR at end of data
//   SMP_TICK            sample-rate strobe
//   MEM_REQ/ADR/ACK/RDATA  VRAM read port, ACK is one cycle with data
//   SND_DATA/SND_VALID  registered PCM sample and its one-cycle strobe
//   PLAY_BUSY/DONE      not idle / end-of-data pulse (non-loop)
//   UNDERRUN            sticky, cleared when play starts from IDLE
//   PLAY_POS            word address of the sample word being output
module snd_playctrl #(
  parameter int AW        = 23,
  parameter int VOL_SHIFT = 7
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic [1:0]    REG_CMD,
  input  logic [AW-1:0] REG_VRAMADR,
  input  logic [AW-1:0] REG_LEN,
  input  logic [7:0]    REG_VOLUME,
  input  logic          REG_LOOP,
  input  logic          REG_MUTE,
  input  logic          SMP_TICK,
  output logic          MEM_REQ,
  output logic [AW-1:0] MEM_ADR,
  input  logic          MEM_ACK,
  input  logic [31:0]   MEM_RDATA,
  output logic [15:0]   SND_DATA,
  output logic          SND_VALID,
  output logic          PLAY_BUSY,
  output logic          PLAY_DONE,
  output logic          UNDERRUN,
  output logic [AW-1:0] PLAY_POS
);

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, PAUSE, DRAIN} state_t;
  state_t state, state_nx;

  logic [AW-1:0] ptr, cnt, adr, nxt_adr, pos;
  logic [31:0]   cur, nxt;
  logic          cur_v, nxt_v, half, req;
  logic [15:0]   snd_data;
  logic          snd_valid, done_q, underrun_q;

  logic stop_cmd, end_of_data;
  logic start, accept_cur, accept_nxt, pf_issue, tick_play, promote, done, clr_out;

  logic signed [15:0] smp;
  logic signed [24:0] prod, shf;
  logic [15:0]        scaled;

  assign stop_cmd    = (REG_CMD == 2'd0) || (REG_CMD == 2'd3);
  // Nothing left to fetch, nothing in flight and nothing buffered.
  assign end_of_data = (cnt == '0) && !req && !nxt_v;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    accept_cur = 1'b0;
    accept_nxt = 1'b0;
    pf_issue   = 1'b0;
    tick_play  = 1'b0;
    promote    = 1'b0;
    done       = 1'b0;
    clr_out    = 1'b0;
    unique case (state)
      IDLE: begin
        // Late acks arriving here are ignored: req is already low.
        if (REG_CMD == 2'd1 && REG_LEN != '0) begin
          start    = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH: begin
        // Ticks before the first word arrives are not played.
        if (stop_cmd) begin
          if (req && !MEM_ACK) state_nx = DRAIN;
          else begin state_nx = IDLE; clr_out = 1'b1; end
        end else if (MEM_ACK) begin
          accept_cur = 1'b1;
          state_nx   = PLAY;
        end
      end
      PLAY: begin
        if (stop_cmd) begin
          if (req && !MEM_ACK) state_nx = DRAIN;
          else begin state_nx = IDLE; clr_out = 1'b1; end
        end else begin
          accept_nxt = req && MEM_ACK;
          promote    = !cur_v && nxt_v;
          if (REG_CMD == 2'd2) begin
            state_nx = PAUSE;
          end else begin
            tick_play = SMP_TICK;
            pf_issue  = !nxt_v && (cnt != '0) && !req;
            if (SMP_TICK && end_of_data && !REG_LOOP && (half || !cur_v)) begin
              done     = 1'b1;
              state_nx = IDLE;
            end
          end
        end
      end
      PAUSE: begin
        if (stop_cmd) begin
          if (req && !MEM_ACK) state_nx = DRAIN;
          else begin state_nx = IDLE; clr_out = 1'b1; end
        end else begin
          accept_nxt = req && MEM_ACK;
          if (REG_CMD == 2'd1) state_nx = PLAY;
        end
      end
      DRAIN: begin
        if (MEM_ACK) begin
          state_nx = IDLE;
          clr_out  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    smp  = half ? cur[31:16] : cur[15:0];
    prod = 25'(smp) * 25'($signed({1'b0, REG_VOLUME}));
    shf  = prod >>> VOL_SHIFT;
    if (REG_MUTE)                  scaled = '0;
    else if (shf > 25'sd32767)     scaled = 16'h7FFF;
    else if (shf < -25'sd32768)    scaled = 16'h8000;
    else                           scaled = shf[15:0];
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      ptr        <= '0;
      cnt        <= '0;
      adr        <= '0;
      nxt_adr    <= '0;
      pos        <= '0;
      cur        <= '0;
      nxt        <= '0;
      cur_v      <= 1'b0;
      nxt_v      <= 1'b0;
      half       <= 1'b0;
      req        <= 1'b0;
      snd_data   <= '0;
      snd_valid  <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      snd_valid <= 1'b0;
      done_q    <= done;

      if (start) begin
        ptr        <= REG_VRAMADR;
        cnt        <= REG_LEN;
        adr        <= REG_VRAMADR;
        req        <= 1'b1;
        underrun_q <= 1'b0;
        cur_v      <= 1'b0;
        nxt_v      <= 1'b0;
        half       <= 1'b0;
      end

      if (pf_issue) begin
        req <= 1'b1;
        adr <= ptr;
      end

      if (req && MEM_ACK) req <= 1'b0;

      if (accept_cur) begin
        cur   <= MEM_RDATA;
        cur_v <= 1'b1;
        half  <= 1'b0;
        pos   <= adr;
        ptr   <= ptr + AW'(1);
        cnt   <= cnt - AW'(1);
      end

      if (accept_nxt) begin
        nxt     <= MEM_RDATA;
        nxt_adr <= adr;
        nxt_v   <= 1'b1;
        ptr     <= ptr + AW'(1);
        cnt     <= cnt - AW'(1);
      end

      // An empty current slot (after underrun or loop reload) takes the
      // buffered word straight away, restarting at the low half.
      if (promote) begin
        cur     <= nxt;
        cur_v   <= 1'b1;
        half    <= 1'b0;
        pos     <= nxt_adr;
        nxt_v   <= 1'b0;
      end

      if (tick_play) begin
        snd_valid <= 1'b1;
        if (cur_v) begin
          snd_data <= scaled;
          if (!half) begin
            half <= 1'b1;
          end else if (nxt_v) begin
            cur   <= nxt;
            half  <= 1'b0;
            pos   <= nxt_adr;
            nxt_v <= 1'b0;
          end else if (end_of_data) begin
            if (REG_LOOP) begin
              ptr   <= REG_VRAMADR;
              cnt   <= REG_LEN;
              cur_v <= 1'b0;
            end
          end else begin
            // Word fully consumed but its successor is still in flight.
            cur_v <= 1'b0;
          end
        end else begin
          snd_data   <= '0;
          underrun_q <= 1'b1;
          if (end_of_data && REG_LOOP) begin
            ptr <= REG_VRAMADR;
            cnt <= REG_LEN;
          end
        end
      end

      if (clr_out) snd_data <= '0;
    end
  end

  assign MEM_REQ   = req;
  assign MEM_ADR   = adr;
  assign SND_DATA  = snd_data;
  assign SND_VALID = snd_valid;
  assign PLAY_BUSY = (state != IDLE);
  assign PLAY_DONE = done_q;
  assign UNDERRUN  = underrun_q;
  assign PLAY_POS  = pos;

endmodule

// File: tb/tb_snd_playctrl.sv
// tb_snd_playctrl -- scoreboard bench for snd_playctrl.
// Stimulus pushes hand-computed PCM values into a queue; a monitor process
// pops one per SND_VALID and compares. The same negedge process models the
// VRAM responder (programmable latency / hold) and logs acked addresses.
module tb_snd_playctrl;
  localparam int AW = 23;

  logic          CLK = 1'b0;
  logic          RST_X;
  logic [1:0]    REG_CMD;
  logic [AW-1:0] REG_VRAMADR;
  logic [AW-1:0] REG_LEN;
  logic [7:0]    REG_VOLUME;
  logic          REG_LOOP;
  logic          REG_MUTE;
  logic          SMP_TICK;
  logic          MEM_REQ;
  logic [AW-1:0] MEM_ADR;
  logic          MEM_ACK;
  logic [31:0]   MEM_RDATA;
  logic [15:0]   SND_DATA;
  logic          SND_VALID;
  logic          PLAY_BUSY;
  logic          PLAY_DONE;
  logic          UNDERRUN;
  logic [AW-1:0] PLAY_POS;

  snd_playctrl #(.AW(23), .VOL_SHIFT(7)) dut (
    .CLK(CLK), .RST_X(RST_X), .REG_CMD(REG_CMD), .REG_VRAMADR(REG_VRAMADR),
    .REG_LEN(REG_LEN), .REG_VOLUME(REG_VOLUME), .REG_LOOP(REG_LOOP),
    .REG_MUTE(REG_MUTE), .SMP_TICK(SMP_TICK), .MEM_REQ(MEM_REQ),
    .MEM_ADR(MEM_ADR), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .SND_DATA(SND_DATA), .SND_VALID(SND_VALID), .PLAY_BUSY(PLAY_BUSY),
    .PLAY_DONE(PLAY_DONE), .UNDERRUN(UNDERRUN), .PLAY_POS(PLAY_POS)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          ack_lat  = 0;
  bit          ack_hold = 1'b0;
  logic [15:0] exp_q[$];
  logic [AW-1:0] adr_log[$];
  logic [31:0] mem [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic tick(input int gap);
    SMP_TICK = 1'b1;
    cyc(1);
    SMP_TICK = 1'b0;
    cyc(gap);
  endtask

  task automatic wait_log(input int n, input string name);
    int k = 0;
    while (adr_log.size() < n && k < 200) begin cyc(1); k++; end
    check(name, adr_log.size(), n);
  endtask

  task automatic start_play(input logic [AW-1:0] a, input logic [AW-1:0] len, input logic loop);
    REG_VRAMADR = a;
    REG_LEN     = len;
    REG_LOOP    = loop;
    REG_CMD     = 2'd1;
  endtask

  initial begin
    RST_X = 1'b0; REG_CMD = 2'd0; REG_VRAMADR = '0; REG_LEN = '0;
    REG_VOLUME = 8'd128; REG_LOOP = 1'b0; REG_MUTE = 1'b0; SMP_TICK = 1'b0;
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    foreach (mem[i]) mem[i] = '0;

    fork
      begin : monitor
        int          wait_cnt = 0;
        bit          pend = 1'b0;
        logic [AW-1:0] pend_adr = '0;
        logic [15:0] e;
        forever begin
          @(negedge CLK);
          if (SND_VALID) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL snd_valid_unexpected: got SND_VALID with 0x%04h, required no sample", SND_DATA);
            end else begin
              e = exp_q.pop_front();
              check("snd_data", {16'h0, SND_DATA}, {16'h0, e});
            end
          end
          if (PLAY_DONE) done_cnt++;
          if (MEM_REQ && pend) check("mem_adr_stable", {9'h0, MEM_ADR}, {9'h0, pend_adr});
          MEM_ACK = 1'b0;
          if (!MEM_REQ) wait_cnt = 0;
          else if (!ack_hold) begin
            if (wait_cnt >= ack_lat) begin
              MEM_ACK   = 1'b1;
              MEM_RDATA = mem[MEM_ADR[3:0]];
              adr_log.push_back(MEM_ADR);
              wait_cnt  = 0;
            end else wait_cnt++;
          end
          pend     = MEM_REQ && !MEM_ACK;
          pend_adr = MEM_ADR;
        end
      end
      begin : watchdog
        repeat (20000) @(posedge CLK);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
      end
    join_none

    cyc(3);
    RST_X = 1'b1;
    cyc(1);
    check("reset_outputs",
          {1'b0, MEM_REQ, SND_VALID, PLAY_BUSY, PLAY_DONE, UNDERRUN, SND_DATA, 3'b0, PLAY_POS[7:0]},
          32'h0);

    // Single word, no loop.
    mem[0] = 32'h8000_1234;
    start_play(23'h100, 23'd1, 1'b0);
    cyc(3);
    check("t1_pos", {9'h0, PLAY_POS}, 32'h100);
    exp_q.push_back(16'h1234); tick(4);
    exp_q.push_back(16'h8000); tick(0);
    REG_CMD = 2'd0;
    check("t1_done_pulse", {31'h0, PLAY_DONE}, 32'h1);
    check("t1_busy_low", {31'h0, PLAY_BUSY}, 32'h0);
    tick(4);
    check("t1_done_count", done_cnt, 1);

    // Volume, saturation and mute.
    mem[0] = 32'h9000_7000; mem[1] = 32'h1234_1000; mem[2] = 32'h0000_0100;
    REG_VOLUME = 8'd255;
    start_play(23'h100, 23'd3, 1'b0);
    cyc(6);
    exp_q.push_back(16'h7FFF); tick(5);
    exp_q.push_back(16'h8000); tick(5);
    check("t2_pos_w1", {9'h0, PLAY_POS}, 32'h101);
    REG_VOLUME = 8'd64;
    exp_q.push_back(16'h0800); tick(5);
    REG_MUTE = 1'b1;
    exp_q.push_back(16'h0000); tick(5);
    check("t2_pos_muted", {9'h0, PLAY_POS}, 32'h102);
    REG_MUTE = 1'b0; REG_VOLUME = 8'd128;
    exp_q.push_back(16'h0100); tick(5);
    exp_q.push_back(16'h0000); tick(0);
    REG_CMD = 2'd0;
    cyc(3);
    check("t2_done_count", done_cnt, 2);

    // Loop over two words.
    mem[0] = 32'h0002_0001; mem[1] = 32'h0004_0003;
    adr_log.delete();
    start_play(23'h100, 23'd2, 1'b1);
    cyc(6);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(16'h0001); tick(5);
      exp_q.push_back(16'h0002); tick(5);
      exp_q.push_back(16'h0003); tick(5);
      exp_q.push_back(16'h0004); tick(0);
      if (r == 0) cyc(5);
    end
    REG_CMD = 2'd0;
    cyc(3);
    check("t3_fetch_count", adr_log.size(), 4);
    if (adr_log.size() == 4) begin
      check("t3_adr0", {9'h0, adr_log[0]}, 32'h100);
      check("t3_adr1", {9'h0, adr_log[1]}, 32'h101);
      check("t3_adr2", {9'h0, adr_log[2]}, 32'h100);
      check("t3_adr3", {9'h0, adr_log[3]}, 32'h101);
    end
    check("t3_no_done", done_cnt, 2);
    check("t3_idle", {31'h0, PLAY_BUSY}, 32'h0);

    // Underrun: prefetch held off for 50 cycles, ticks every 4 cycles.
    mem[0] = 32'h0022_0011; mem[1] = 32'h0044_0033;
    adr_log.delete();
    start_play(23'h100, 23'd2, 1'b0);
    cyc(2);
    ack_lat = 50;
    exp_q.push_back(16'h0011); tick(3);
    exp_q.push_back(16'h0022); tick(3);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(16'h0000); tick(3);
    end
    check("t4_underrun_set", {31'h0, UNDERRUN}, 32'h1);
    wait_log(2, "t4_late_ack");
    cyc(3);
    check("t4_pos_resume", {9'h0, PLAY_POS}, 32'h101);
    exp_q.push_back(16'h0033); tick(3);
    exp_q.push_back(16'h0044); tick(0);
    REG_CMD = 2'd0;
    ack_lat = 0;
    cyc(2);
    check("t4_underrun_sticky", {31'h0, UNDERRUN}, 32'h1);
    check("t4_done_count", done_cnt, 3);

    // Pause and resume mid-word.
    mem[0] = 32'h0B0B_0A0A;
    start_play(23'h100, 23'd1, 1'b0);
    cyc(3);
    check("t5_underrun_cleared", {31'h0, UNDERRUN}, 32'h0);
    exp_q.push_back(16'h0A0A); tick(0);
    REG_CMD = 2'd2;
    cyc(2);
    for (int i = 0; i < 5; i++) tick(2);
    check("t5_busy_paused", {31'h0, PLAY_BUSY}, 32'h1);
    check("t5_hold_data", {16'h0, SND_DATA}, 32'h0A0A);
    REG_CMD = 2'd1;
    cyc(2);
    exp_q.push_back(16'h0B0B); tick(0);
    REG_CMD = 2'd0;
    cyc(2);
    check("t5_done_count", done_cnt, 4);

    // Stop while a request is outstanding.
    ack_hold = 1'b1;
    mem[0] = 32'h7777_7777;
    start_play(23'h100, 23'd2, 1'b0);
    cyc(4);
    REG_CMD = 2'd0;
    cyc(5);
    check("t6_req_held", {31'h0, MEM_REQ}, 32'h1);
    check("t6_busy_drain", {31'h0, PLAY_BUSY}, 32'h1);
    ack_hold = 1'b0;
    begin
      int k = 0;
      while (MEM_REQ && k < 50) begin cyc(1); k++; end
    end
    check("t6_req_dropped", {31'h0, MEM_REQ}, 32'h0);
    cyc(2);
    check("t6_idle", {31'h0, PLAY_BUSY}, 32'h0);
    check("t6_snd_cleared", {16'h0, SND_DATA}, 32'h0);
    check("t6_no_done", done_cnt, 4);

    cyc(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
